// File: rtl/serial_frame_pkg.sv
// Shared constants for the serial frame deserializer: FSM state encodings
// and the line levels that delimit a UART-style frame.
package serial_frame_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sfd_holding_buffer.sv
// One-entry valid/ready holding buffer for assembled words. A commit into a
// full buffer that is not being drained drops the new word and pulses overflow.
module sfd_holding_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit,
    input  logic [WIDTH-1:0] commit_word,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             overflow
);

    // Load on commit when empty or draining this cycle, otherwise flag overflow; drain on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (commit) begin
                if (!word_valid || word_ready) begin
                    word_out   <= commit_word;
                    word_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Serial frame deserializer: frames the registered serial line (start 0,
// WIDTH data bits LSB-first, optional even parity, stop 1) on bit_en strobes
// and hands completed words to a one-entry holding buffer.
// Optional feature macro: SERIAL_FRAME_DESERIALIZER_PARITY_EN adds a parity bit
// between the data bits and the stop bit.
module serial_frame_deserializer
    import serial_frame_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overflow,
    output logic             parity_err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] shift_reg;
    logic             parity_bad;
    logic             commit;

`ifdef SERIAL_FRAME_DESERIALIZER_PARITY_EN
    logic parity_bit;

    // Capture the received parity bit so it can be judged together with the stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_bit <= 1'b0;
        end else if (bit_en && state == PARITY) begin
            parity_bit <= serial_in;
        end
    end

    assign parity_bad = (parity_bit != ^shift_reg);
`else
    assign parity_bad = 1'b0;
`endif

    assign commit = bit_en && (state == STOP) && (serial_in == STOP_BIT) && !parity_bad;
    assign busy   = (state != IDLE);

    // Frame FSM: hunt for a start bit, shift data LSB-first, then judge the stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            shift_reg  <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (serial_in == START_BIT) begin
                            state <= DATA;
                            count <= '0;
                        end
                    end
                    DATA: begin
                        shift_reg <= {serial_in, shift_reg[WIDTH-1:1]};
                        count     <= count + 1'b1;
                        if (count == LAST_IDX) begin
`ifdef SERIAL_FRAME_DESERIALIZER_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
`ifdef SERIAL_FRAME_DESERIALIZER_PARITY_EN
                    PARITY: begin
                        state <= STOP;
                    end
`endif
                    STOP: begin
                        if (serial_in == STOP_BIT) begin
                            parity_err <= parity_bad;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    sfd_holding_buffer #(
        .WIDTH(WIDTH)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .commit     (commit),
        .commit_word(shift_reg),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .overflow   (overflow)
    );

endmodule
